// File: rtl/writeback_pkg.sv
// Shared types for the writeback arbiter slice: buffered result entries and the
// register file write-port record.
package writeback_pkg;

  localparam int MaxSourceCount = 8;

  typedef struct packed {
    logic [4:0]  address;
    logic [31:0] data;
  } writeback_result_t;

  typedef struct packed {
    logic        enable;
    logic [4:0]  address;
    logic [31:0] data;
  } register_file_write_t;

  // One-hot destination mask; x0 never counts as a pending destination.
  function automatic logic [31:0] dest_mask(input logic [4:0] address);
    return (32'd1 << address) & ~32'd1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result handshake bundle between the execution sources and the writeback arbiter.
interface writeback_arbiter_if #(
  parameter int SourceCount = 3
);

  logic [SourceCount-1:0]       result_valid_i;
  logic [SourceCount-1:0]       result_ready_o;
  logic [SourceCount-1:0][4:0]  result_address_i;
  logic [SourceCount-1:0][31:0] result_data_i;

  modport master (
    output result_valid_i,
    output result_address_i,
    output result_data_i,
    input  result_ready_o
  );

  modport slave (
    input  result_valid_i,
    input  result_address_i,
    input  result_data_i,
    output result_ready_o
  );

endinterface

// File: rtl/writeback_arbiter_result_fifo.sv
// result_fifo: per-source result buffer with registered count/full and a bitmap
// of the destinations currently held.
module result_fifo
  import writeback_pkg::*;
#(
  parameter int  Depth = 2,
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  writeback_result_t data_i,
  input  logic              pop_i,
  output writeback_result_t head_o,
  output logic [CntW-1:0]   count_o,
  output logic              full_o,
  output logic [31:0]       pending_o
);

  writeback_result_t mem_r [Depth];
  logic [Depth-1:0]  valid_r;
  logic [Depth-1:0]  valid_next_s;
  logic [PtrW-1:0]   wr_ptr_r;
  logic [PtrW-1:0]   rd_ptr_r;
  logic [CntW-1:0]   count_r;
  logic              push_s;
  logic              pop_s;
  logic [31:0]       pending_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o = (count_r == CntW'(Depth));
  assign push_s = push_i & ~full_o;
  assign pop_s  = pop_i & (count_r != '0);

  // Slot occupancy: a pop frees the head slot, a push fills the tail slot.
  always_comb begin
    valid_next_s           = valid_r;
    valid_next_s[rd_ptr_r] = valid_r[rd_ptr_r] & ~pop_s;
    valid_next_s[wr_ptr_r] = valid_next_s[wr_ptr_r] | push_s;
  end

  // Pointer, count and occupancy state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      valid_r  <= valid_next_s;
      wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; validity lives in valid_r so the array itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Destinations of every occupied slot.
  always_comb begin
    pending_s = 32'd0;
    for (int i = 0; i < Depth; i++) begin
      pending_s = pending_s | (valid_r[i] ? dest_mask(mem_r[i].address) : 32'd0);
    end
  end

  assign head_o    = mem_r[rd_ptr_r];
  assign count_o   = count_r;
  assign pending_o = pending_s;

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers results from several producers and serialises them
// round-robin onto register file write port 0. Optional: WRITEBACK_PERF_COUNTERS_EN.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int  SourceCount = 3,
  parameter int  BufferDepth = 2,
  localparam int RrW         = (SourceCount > 1) ? $clog2(SourceCount) : 1,
  localparam int CntW        = $clog2(BufferDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  writeback_arbiter_if.slave   result_if,
  output register_file_write_t write_o,
  output logic [31:0]          pending_o
`ifdef WRITEBACK_PERF_COUNTERS_EN
  ,
  output logic [31:0]          stall_cycles_o
`endif
);

  logic [SourceCount-1:0] full_s;
  logic [SourceCount-1:0] ready_s;
  logic [SourceCount-1:0] push_s;
  logic [SourceCount-1:0] pop_s;
  logic [SourceCount-1:0] candidate_s;
  writeback_result_t      in_s [SourceCount];
  writeback_result_t      head_s [SourceCount];
  logic [CntW-1:0]        count_s [SourceCount];
  logic [31:0]            fifo_pending_s [SourceCount];
  logic [RrW-1:0]         rr_r;
  logic [RrW-1:0]         rr_next_s;
  logic [RrW-1:0]         grant_idx_s;
  logic                   grant_valid_s;
  writeback_result_t      grant_head_s;
  register_file_write_t   write_r;
  logic [31:0]            pending_s;

  // Ready comes only from registered fullness, so there is no valid->ready path.
  assign ready_s                  = rst_ni ? ~full_s : '0;
  assign result_if.result_ready_o = ready_s;

  for (genvar s = 0; s < SourceCount; s++) begin : g_src
    assign in_s[s]        = '{address: result_if.result_address_i[s],
                              data:    result_if.result_data_i[s]};
    // Writes to x0 complete the handshake but are never buffered.
    assign push_s[s]      = result_if.result_valid_i[s] & ready_s[s] &
                            (result_if.result_address_i[s] != 5'd0);
    assign candidate_s[s] = (count_s[s] != '0);
    assign pop_s[s]       = grant_valid_s & (grant_idx_s == RrW'(s));

    result_fifo #(
      .Depth (BufferDepth)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push_i    (push_s[s]),
      .data_i    (in_s[s]),
      .pop_i     (pop_s[s]),
      .head_o    (head_s[s]),
      .count_o   (count_s[s]),
      .full_o    (full_s[s]),
      .pending_o (fifo_pending_s[s])
    );
  end

  // Round-robin scan starting at rr_r, wrapping modulo SourceCount.
  always_comb begin
    logic [RrW:0]   sum_v;
    logic [RrW-1:0] idx_v;
    logic           take_v;
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    sum_v         = '0;
    idx_v         = '0;
    take_v        = 1'b0;
    for (int k = 0; k < SourceCount; k++) begin
      sum_v         = {1'b0, rr_r} + (RrW + 1)'(k);
      idx_v         = (sum_v >= (RrW + 1)'(SourceCount)) ?
                      RrW'(sum_v - (RrW + 1)'(SourceCount)) : RrW'(sum_v);
      take_v        = ~grant_valid_s & candidate_s[idx_v];
      grant_idx_s   = take_v ? idx_v : grant_idx_s;
      grant_valid_s = grant_valid_s | take_v;
    end
  end

  assign grant_head_s = head_s[grant_idx_s];
  assign rr_next_s    = (grant_idx_s == RrW'(SourceCount - 1)) ? '0 : grant_idx_s + RrW'(1);

  // Output register and round-robin pointer; address/data hold when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_r    <= '0;
      write_r <= '0;
    end else if (grant_valid_s) begin
      rr_r    <= rr_next_s;
      write_r <= '{enable: 1'b1, address: grant_head_s.address, data: grant_head_s.data};
    end else begin
      rr_r           <= rr_r;
      write_r.enable <= 1'b0;
    end
  end

  // Pending bitmap: all buffered destinations plus the write being committed.
  always_comb begin
    pending_s = write_r.enable ? dest_mask(write_r.address) : 32'd0;
    for (int s = 0; s < SourceCount; s++) begin
      pending_s = pending_s | fifo_pending_s[s];
    end
  end

  assign write_o   = write_r;
  assign pending_o = pending_s;

`ifdef WRITEBACK_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_r;
  logic        any_stall_s;

  assign any_stall_s = |(result_if.result_valid_i & ~ready_s);

  // Saturating count of cycles in which some offered result was refused.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cycles_r <= 32'd0;
    end else if (any_stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles_o = stall_cycles_r;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table plus randomized traffic
// against a queue-based reference model.
module tb_writeback_arbiter;
  import writeback_pkg::*;

  localparam int N = 3;
  localparam int D = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  register_file_write_t write_s;
  logic [31:0]          pending_s;
`ifdef WRITEBACK_PERF_COUNTERS_EN
  logic [31:0]          stall_s;
`endif

  writeback_arbiter_if #(.SourceCount(N)) rif ();

  writeback_arbiter #(
    .SourceCount (N),
    .BufferDepth (D)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .result_if (rif),
    .write_o   (write_s),
    .pending_o (pending_s)
`ifdef WRITEBACK_PERF_COUNTERS_EN
    ,
    .stall_cycles_o (stall_s)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  writeback_result_t    mq [N][$];
  int                   m_rr = 0;
  register_file_write_t m_wr = '0;
`ifdef WRITEBACK_PERF_COUNTERS_EN
  logic [31:0]          m_stall = 32'd0;
`endif

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int s = 0; s < N; s++) r[s] = rst_n && (mq[s].size() < D);
    return r;
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = m_wr.enable ? (32'd1 << m_wr.address) : 32'd0;
    for (int s = 0; s < N; s++)
      for (int i = 0; i < mq[s].size(); i++) p = p | (32'd1 << mq[s][i].address);
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_edge();
    logic [N-1:0]      rdy;
    int                g;
    writeback_result_t h;
    if (!rst_n) begin
      for (int s = 0; s < N; s++) mq[s].delete();
      m_rr = 0;
      m_wr = '0;
`ifdef WRITEBACK_PERF_COUNTERS_EN
      m_stall = 32'd0;
`endif
    end else begin
      rdy = model_ready();
`ifdef WRITEBACK_PERF_COUNTERS_EN
      if (|(rif.result_valid_i & ~rdy) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
      end
      if (g >= 0) begin
        h    = mq[g].pop_front();
        m_wr = '{enable: 1'b1, address: h.address, data: h.data};
        m_rr = (g + 1) % N;
      end else begin
        m_wr.enable = 1'b0;
      end
      for (int s = 0; s < N; s++) begin
        if (rif.result_valid_i[s] && rdy[s] && rif.result_address_i[s] != 5'd0)
          mq[s].push_back('{address: rif.result_address_i[s], data: rif.result_data_i[s]});
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [N-1:0] v,
                       input logic [N-1:0][4:0] a, input logic [N-1:0][31:0] d);
    rst_n                = r;
    rif.result_valid_i   = v;
    rif.result_address_i = a;
    rif.result_data_i    = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_ready", 64'(rif.result_ready_o), 64'(model_ready()));
    check("model_write", 64'(write_s), 64'(m_wr));
    check("model_pending", 64'(pending_s), 64'(model_pending()));
`ifdef WRITEBACK_PERF_COUNTERS_EN
    check("model_stall", 64'(stall_s), 64'(m_stall));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               rst;
    logic [N-1:0]       valid;
    logic [N-1:0][4:0]  addr;
    logic [N-1:0][31:0] data;
    logic [N-1:0]       exp_ready;
    logic               exp_en;
    logic [4:0]         exp_addr;
    logic [31:0]        exp_data;
    logic [31:0]        exp_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [2:0] v,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [2:0] er, input logic een, input logic [4:0] ea,
                     input logic [31:0] ed, input logic [31:0] ep);
    vec_t t;
    t.rst = r;  t.valid = v;
    t.addr = {a2, a1, a0};  t.data = {d2, d1, d0};
    t.exp_ready = er;  t.exp_en = een;  t.exp_addr = ea;  t.exp_data = ed;  t.exp_pend = ep;
    tbl.push_back(t);
  endtask

  initial begin
    logic [N-1:0]       rv;
    logic [N-1:0][4:0]  ra;
    logic [N-1:0][31:0] rd;
    logic               rr;

    // reset held 3 cycles with every source offering, then release
    for (int i = 0; i < 3; i++)
      add(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'hA, 32'hB, 32'hC, 3'b000, 1'b0, 5'd0, 32'd0, 32'd0);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd0, 32'd0, 32'd0);
    // single result x5
    add(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 3'b111, 1'b0, 5'd0, 32'd0, 32'h20);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd5, 32'hDEADBEEF, 32'h20);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
    // reset to rr=0, then simultaneous burst x1/x2/x3
    add(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 5'd0, 32'd0, 32'd0);
    add(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b111, 1'b0, 5'd0, 32'd0, 32'hE);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd1, 32'h11, 32'hE);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd2, 32'h22, 32'hC);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd3, 32'h33, 32'h8);
    // second burst resumes from rr=1 after a lone source-0 grant
    add(1'b1, 3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'd0, 32'd0, 3'b111, 1'b0, 5'd3, 32'h33, 32'h10);
    add(1'b1, 3'b111, 5'd7, 5'd8, 5'd9, 32'h77, 32'h88, 32'h99, 3'b111, 1'b1, 5'd4, 32'h44, 32'h390);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd8, 32'h88, 32'h380);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd9, 32'h99, 32'h280);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd7, 32'h77, 32'h80);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd7, 32'h77, 32'h0);
    // x0 write from source 2 is accepted and dropped
    add(1'b1, 3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1234, 3'b111, 1'b0, 5'd7, 32'h77, 32'h0);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd7, 32'h77, 32'h0);
    // backpressure on source 1 while sources 0 and 2 hold entries
    add(1'b1, 3'b101, 5'd10, 5'd0, 5'd12, 32'hA1, 32'd0, 32'hC1, 3'b111, 1'b0, 5'd7, 32'h77, 32'h1400);
    add(1'b1, 3'b111, 5'd13, 5'd11, 5'd15, 32'hA2, 32'hB1, 32'hC2, 3'b110, 1'b1, 5'd12, 32'hC1, 32'hBC00);
    add(1'b1, 3'b010, 5'd0, 5'd14, 5'd0, 32'd0, 32'hB2, 32'd0, 3'b101, 1'b1, 5'd10, 32'hA1, 32'hEC00);
    add(1'b1, 3'b010, 5'd0, 5'd16, 5'd0, 32'd0, 32'hB3, 32'd0, 3'b111, 1'b1, 5'd11, 32'hB1, 32'hE800);
    add(1'b1, 3'b010, 5'd0, 5'd16, 5'd0, 32'd0, 32'hB3, 32'd0, 3'b101, 1'b1, 5'd15, 32'hC2, 32'h1E000);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b101, 1'b1, 5'd13, 32'hA2, 32'h16000);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd14, 32'hB2, 32'h14000);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd16, 32'hB3, 32'h10000);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd16, 32'hB3, 32'h0);
    // mid-operation reset with four results queued
    add(1'b1, 3'b111, 5'd20, 5'd21, 5'd22, 32'hD0, 32'hD1, 32'hD2, 3'b111, 1'b0, 5'd16, 32'hB3, 32'h700000);
    add(1'b1, 3'b001, 5'd23, 5'd0, 5'd0, 32'hD3, 32'd0, 32'd0, 3'b110, 1'b1, 5'd22, 32'hD2, 32'hF00000);
    add(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 3'b000, 1'b0, 5'd0, 32'd0, 32'h0);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd0, 32'd0, 32'h0);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd0, 32'd0, 32'h0);
    // rr back at 0 after that reset
    add(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'hE0, 32'hE1, 32'hE2, 3'b111, 1'b0, 5'd0, 32'd0, 32'hE);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd1, 32'hE0, 32'hE);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd2, 32'hE1, 32'hC);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b1, 5'd3, 32'hE2, 32'h8);
    add(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b111, 1'b0, 5'd3, 32'hE2, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].valid, tbl[i].addr, tbl[i].data);
      check($sformatf("vec%0d_ready", i), 64'(rif.result_ready_o), 64'(tbl[i].exp_ready));
      check($sformatf("vec%0d_enable", i), 64'(write_s.enable), 64'(tbl[i].exp_en));
      check($sformatf("vec%0d_address", i), 64'(write_s.address), 64'(tbl[i].exp_addr));
      check($sformatf("vec%0d_data", i), 64'(write_s.data), 64'(tbl[i].exp_data));
      check($sformatf("vec%0d_pending", i), 64'(pending_s), 64'(tbl[i].exp_pend));
    end

    // randomized traffic with occasional resets and x0 destinations
    for (int c = 0; c < 600; c++) begin
      rr = ($urandom_range(0, 63) != 0);
      for (int s = 0; s < N; s++) begin
        rv[s] = ($urandom_range(0, 3) != 0);
        ra[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rd[s] = $urandom;
      end
      cycle(rr, rv, ra, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
